fir_filter: RTL and testbench
=============================

FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 Parameter N, default 4: number of taps, N >= 1.
REQ-002 Parameter TYPE, default "NORMAL": architecture select, either "NORMAL" (direct form) or "TRANSPOSED".
REQ-003 Parameter WIDTH_X, default 4: input sample width, signed two's complement.
REQ-004 Parameter WIDTH_B, default 4: coefficient width, signed two's complement.
REQ-005 Parameter WIDTH_Y, default WIDTH_X+WIDTH_B: output width, signed two's complement.
REQ-006 Parameter B, default {1,2,3,4}: unpacked array [N] of WIDTH_B-bit coefficients; B[0] applies to the newest sample.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 Port rstn, input, 1 bit: reset, asynchronous and active-high (asserted = 1); the port keeps the codebase name rstn.
REQ-009 Port x, input, signed [WIDTH_X-1:0]: input sample, taken on every rising clk edge.
REQ-010 Port y, output, signed [WIDTH_Y-1:0]: registered filter output.

Function
REQ-011 The filter SHALL have no handshake; a new x is consumed on every rising clk edge while reset is deasserted.
REQ-012 Let x[k] be the x value sampled at edge k. After edge k+1, y SHALL equal sum over i=0..N-1 of B[i]*x[k-i].
REQ-013 Samples taken before reset deassertion, or at edges before the first post-reset edge, SHALL count as 0 in that sum.
REQ-014 Consequently an input sampled at edge k first affects y after edge k+1: latency is 1 clock from sampling to output.
REQ-015 Multiplications SHALL be signed x signed.
REQ-016 Accumulation SHALL run at full precision, WIDTH_X+WIDTH_B+$clog2(N) bits.
REQ-017 The result SHALL be truncated to the WIDTH_Y LSBs (wrap, no saturation) when WIDTH_Y is narrower, and sign-extended when WIDTH_Y is wider.
REQ-018 TYPE "NORMAL" SHALL use an N-deep input delay line and an adder tree feeding an output register.
REQ-019 TYPE "TRANSPOSED" SHALL use a registered partial-sum chain.
REQ-020 Both TYPE values SHALL produce bit-identical y on every cycle.
REQ-021 Any other TYPE value SHALL cause an elaboration-time error.
REQ-022 Coefficients SHALL be compile-time constants; there is no runtime coefficient load.

Reset
REQ-023 While rstn = 1, all delay-line and partial-sum registers and y SHALL be 0, immediately and independent of clk.
REQ-024 After rstn falls, the first rising edge SHALL sample x normally; history older than that edge SHALL read as 0.
REQ-025 A reset asserted mid-stream SHALL clear all history; no pre-reset sample may affect y after reset is released.

Structure
REQ-026 A shared package fir_pkg SHALL hold the TYPE string constants and an accumulator-width function (WIDTH_X+WIDTH_B+$clog2(N)).
REQ-027 One sub-module fir_tap SHALL implement one signed multiply plus its tap register; fir_filter instantiates N of them in a generate loop.

Verification (defaults: N=4, B={1,2,3,4}, WIDTH_Y=8)
REQ-028 Impulse: x=1 for one edge k, then 0 -> y after edges k+1..k+4 = 1,2,3,4, then 0.
REQ-029 Negative step: x=-8 held -> y after successive edges = -8, -24, -48, then -80 steady.
REQ-030 Reset mid-stream: x=7 held, then pulse rstn=1 between edges -> y=0 immediately; after release, y ramps 7, 21, 42, 70.
REQ-031 Alternating input: x=+7,-8,+7,-8... -> y matches a reference-model convolution every cycle, no mismatch.
REQ-032 Random: 500 random x values with a model check each cycle, run for both TYPE values -> zero mismatches, and TYPE "NORMAL" vs "TRANSPOSED" outputs identical.
REQ-033 Truncation: WIDTH_Y=6, x=-8 held -> steady y = (-80 mod 64), interpreted signed = -16.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and helpers for the FIR filter
package fir_pkg;

  localparam string FIR_TYPE_NORMAL     = "NORMAL";
  localparam string FIR_TYPE_TRANSPOSED = "TRANSPOSED";

  // Full-precision accumulator width: product width plus growth for N terms
  function automatic int fir_acc_width(input int width_x, input int width_b, input int n);
    return width_x + width_b + $clog2(n);
  endfunction

endpackage

// File: rtl/fir_tap.sv
// rtl/fir_tap.sv - one FIR tap: signed multiply plus its tap register
module fir_tap #(
  parameter int                        WIDTH_X    = 4,
  parameter int                        WIDTH_B    = 4,
  parameter int                        WIDTH_A    = 10,
  parameter logic signed [WIDTH_B-1:0] COEF       = '0,
  parameter bit                        TRANSPOSED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic signed [WIDTH_X-1:0] x_in,
  input  logic signed [WIDTH_A-1:0] sum_in,
  output logic signed [WIDTH_X-1:0] x_out,
  output logic signed [WIDTH_A-1:0] sum_out
);

  localparam int WIDTH_P = WIDTH_X + WIDTH_B;

  logic signed [WIDTH_X-1:0] mult_x;
  logic signed [WIDTH_P-1:0] prod;
  logic signed [WIDTH_A-1:0] prod_ext;

  // Signed x signed product, sign-extended to the accumulator width
  always_comb begin
    prod     = WIDTH_P'(mult_x) * WIDTH_P'(COEF);
    prod_ext = WIDTH_A'(prod);
  end

  if (TRANSPOSED) begin : g_transposed
    logic signed [WIDTH_A-1:0] acc_d;
    logic signed [WIDTH_A-1:0] acc_q;

    assign mult_x  = x_in;
    assign x_out   = x_in;
    assign sum_out = acc_q;

    // Next partial sum: this tap's product plus the downstream partial sum
    always_comb begin
      acc_d = sum_in + prod_ext;
    end

    // Partial-sum register, cleared asynchronously
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) acc_q <= '0;
      else      acc_q <= acc_d;
    end
  end else begin : g_normal
    logic signed [WIDTH_X-1:0] x_d;
    logic signed [WIDTH_X-1:0] x_q;

    assign mult_x  = x_q;
    assign x_out   = x_q;
    assign sum_out = sum_in + prod_ext;

    // Delay-line stage takes the previous stage's sample
    always_comb begin
      x_d = x_in;
    end

    // Delay-line register, cleared asynchronously
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) x_q <= '0;
      else      x_q <= x_d;
    end
  end

endmodule

// File: rtl/fir_filter.sv
// rtl/fir_filter.sv - N-tap FIR filter, direct or transposed form
module fir_filter
  import fir_pkg::*;
#(
  parameter int                        N       = 4,
  parameter string                     TYPE    = "NORMAL",
  parameter int                        WIDTH_X = 4,
  parameter int                        WIDTH_B = 4,
  parameter int                        WIDTH_Y = WIDTH_X + WIDTH_B,
  parameter logic signed [WIDTH_B-1:0] B [N]   = '{WIDTH_B'(1), WIDTH_B'(2), WIDTH_B'(3), WIDTH_B'(4)}
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic signed [WIDTH_X-1:0] x,
  output logic signed [WIDTH_Y-1:0] y
);

  localparam int WIDTH_A       = fir_acc_width(WIDTH_X, WIDTH_B, N);
  localparam bit IS_TRANSPOSED = (TYPE == FIR_TYPE_TRANSPOSED);

  if (TYPE != FIR_TYPE_NORMAL && TYPE != FIR_TYPE_TRANSPOSED) begin : g_bad_type
    $error("fir_filter: TYPE must be NORMAL or TRANSPOSED");
  end

  logic signed [WIDTH_X-1:0] x_chain   [N+1];
  logic signed [WIDTH_A-1:0] sum_chain [N+1];
  logic signed [WIDTH_Y-1:0] acc_fit;
  logic                      unused_tail;

  assign sum_chain[N] = '0;
  assign unused_tail  = ^x_chain[N];

  for (genvar i = 0; i < N; i++) begin : g_tap
    fir_tap #(
      .WIDTH_X   (WIDTH_X),
      .WIDTH_B   (WIDTH_B),
      .WIDTH_A   (WIDTH_A),
      .COEF      (B[i]),
      .TRANSPOSED(IS_TRANSPOSED)
    ) u_tap (
      .clk    (clk),
      .rstn   (rstn),
      .x_in   (x_chain[i]),
      .sum_in (sum_chain[i+1]),
      .x_out  (x_chain[i+1]),
      .sum_out(sum_chain[i])
    );
  end

  // Fit the full-precision sum to the output: wrap when narrower, sign-extend when wider
  if (WIDTH_Y <= WIDTH_A) begin : g_trunc
    assign acc_fit = sum_chain[0][WIDTH_Y-1:0];
    if (WIDTH_Y < WIDTH_A) begin : g_drop
      logic unused_msbs;
      assign unused_msbs = ^sum_chain[0][WIDTH_A-1:WIDTH_Y];
    end
  end else begin : g_extend
    assign acc_fit = {{(WIDTH_Y-WIDTH_A){sum_chain[0][WIDTH_A-1]}}, sum_chain[0]};
  end

  if (IS_TRANSPOSED) begin : g_transposed
    logic signed [WIDTH_X-1:0] x_d;
    logic signed [WIDTH_X-1:0] x_q;

    // The input register supplies the extra cycle so both forms share the same latency
    assign x_chain[0] = x_q;
    assign y          = acc_fit;

    // Sample the input every edge
    always_comb begin
      x_d = x;
    end

    // Input register, cleared asynchronously
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) x_q <= '0;
      else      x_q <= x_d;
    end
  end else begin : g_normal
    logic signed [WIDTH_Y-1:0] y_d;
    logic signed [WIDTH_Y-1:0] y_q;

    assign x_chain[0] = x;
    assign y          = y_q;

    // Output register captures the adder result over the delay line
    always_comb begin
      y_d = acc_fit;
    end

    // Output register, cleared asynchronously
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) y_q <= '0;
      else      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// tb/tb_fir_filter.sv - self-checking bench for fir_filter
module tb_fir_filter;

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [3:0] x;
  logic signed [7:0] y_n;
  logic signed [7:0] y_t;
  logic signed [5:0] y_w;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hist[4];
  int coef[4] = '{1, 2, 3, 4};

  always #5 clk = ~clk;

  fir_filter #(.TYPE("NORMAL")) dut_n (
    .clk(clk), .rstn(rstn), .x(x), .y(y_n)
  );

  fir_filter #(.TYPE("TRANSPOSED")) dut_t (
    .clk(clk), .rstn(rstn), .x(x), .y(y_t)
  );

  fir_filter #(.TYPE("TRANSPOSED"), .WIDTH_Y(6)) dut_w (
    .clk(clk), .rstn(rstn), .x(x), .y(y_w)
  );

  function automatic int model_next(input int xv);
    int acc = 0;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = xv;
    for (int i = 0; i < 4; i++) acc += coef[i] * hist[i];
    return acc;
  endfunction

  function automatic logic signed [7:0] wrap8(input int v);
    return v[7:0];
  endfunction

  function automatic logic signed [5:0] wrap6(input int v);
    return v[5:0];
  endfunction

  task automatic tick(input int xv, input bit use_c, input int cexp);
    int e;
    int full;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if (y_n !== wrap8(e)) begin
        errors++;
        $display("FAIL y_normal t=%0t got %0d want %0d", $time, y_n, wrap8(e));
      end
      checks++;
      if (y_t !== wrap8(e)) begin
        errors++;
        $display("FAIL y_transposed t=%0t got %0d want %0d", $time, y_t, wrap8(e));
      end
      checks++;
      if (y_w !== wrap6(e)) begin
        errors++;
        $display("FAIL y_width6 t=%0t got %0d want %0d", $time, y_w, wrap6(e));
      end
      checks++;
      if (y_t !== y_n) begin
        errors++;
        $display("FAIL normal_vs_transposed t=%0t transposed %0d normal %0d", $time, y_t, y_n);
      end
    end
    x = 4'(xv);
    full = model_next(xv);
    exp_q.push_back(use_c ? cexp : full);
  endtask

  task automatic release_reset(input int xv, input bit use_c, input int cexp);
    int full;
    exp_q.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    rstn = 1'b0;
    x = 4'(xv);
    full = model_next(xv);
    exp_q.push_back(use_c ? cexp : full);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (y_n !== 8'sd0) begin errors++; $display("FAIL %s_normal got %0d want 0", tag, y_n); end
    checks++;
    if (y_t !== 8'sd0) begin errors++; $display("FAIL %s_transposed got %0d want 0", tag, y_t); end
    checks++;
    if (y_w !== 6'sd0) begin errors++; $display("FAIL %s_width6 got %0d want 0", tag, y_w); end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    x = 4'sd5;
    repeat (3) @(negedge clk);
    check_zero("reset");
    release_reset(0, 1'b1, 0);
  endtask

  task automatic test_impulse();
    tick(1, 1'b1, 1);
    tick(0, 1'b1, 2);
    tick(0, 1'b1, 3);
    tick(0, 1'b1, 4);
    tick(0, 1'b1, 0);
    tick(0, 1'b1, 0);
  endtask

  task automatic test_neg_step();
    tick(-8, 1'b1, -8);
    tick(-8, 1'b1, -24);
    tick(-8, 1'b1, -48);
    tick(-8, 1'b1, -80);
    tick(-8, 1'b1, -80);
    tick(-8, 1'b1, -80);
    checks++;
    if (y_n !== -8'sd80) begin errors++; $display("FAIL step_steady got %0d want -80", y_n); end
    checks++;
    if (y_w !== -6'sd16) begin errors++; $display("FAIL trunc_steady got %0d want -16", y_w); end
  endtask

  task automatic test_mid_reset();
    repeat (4) tick(7, 1'b0, 0);
    #2 rstn = 1'b1;
    #1 check_zero("mid_reset");
    #1 release_reset(7, 1'b1, 7);
    tick(7, 1'b1, 21);
    tick(7, 1'b1, 42);
    tick(7, 1'b1, 70);
    tick(7, 1'b1, 70);
    tick(7, 1'b1, 70);
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 20; i++) tick((i % 2 == 0) ? 7 : -8, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) tick(int'($urandom_range(15, 0)) - 8, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_neg_step();
    test_mid_reset();
    test_alternating();
    test_random();
    tick(0, 1'b0, 0);
    tick(0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
